// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle sequencer: FSM state encoding,
// reset PC default and decoder opcode-class helpers.
package mc_pkg;

  // Default PC loaded at reset.
  localparam logic [31:0] MC_RESET_PC = 32'h1c00_0000;

  // Number of decoder classification bits carried into the sequencer.
  localparam int OPC_CLS_W = 4;

  // One-hot sequencer states.
  typedef enum logic [6:0] {
    IF_REQ   = 7'b000_0001,
    IF_WAIT  = 7'b000_0010,
    ID       = 7'b000_0100,
    EXE      = 7'b000_1000,
    MEM_REQ  = 7'b001_0000,
    MEM_WAIT = 7'b010_0000,
    WB       = 7'b100_0000
  } mc_state_e;

  // Raw decoder flags as presented in ID.
  typedef struct packed {
    logic br_only;
    logic load;
    logic store;
    logic wr_en;
  } mc_dec_t;

  // Resolved instruction class after precedence.
  typedef enum logic [1:0] {
    CLS_ALU   = 2'd0,
    CLS_BR    = 2'd1,
    CLS_LOAD  = 2'd2,
    CLS_STORE = 2'd3
  } mc_cls_e;

  // Branch-only wins over load, load wins over store, the rest is ALU.
  function automatic mc_cls_e classify(mc_dec_t d);
    if (d.br_only)    return CLS_BR;
    else if (d.load)  return CLS_LOAD;
    else if (d.store) return CLS_STORE;
    else              return CLS_ALU;
  endfunction

endpackage

// File: rtl/mc_req_port.sv
// Request/response handshake tracker for one memory port. Holds req until
// addr_ok, then flags a response as effective only once the address phase
// has completed on an earlier edge, so stray data_ok pulses are dropped.
module mc_req_port (
  input  logic clk,
  input  logic resetn,
  input  logic issue_i,    // sequencer is in (or entering) the request state
  input  logic addr_ok_i,
  input  logic data_ok_i,
  output logic req_o,
  output logic acc_o,      // address phase accepted this cycle
  output logic resp_o      // effective data response this cycle
);

  logic req_q;
  logic wait_q;

  assign req_o  = req_q;
  assign acc_o  = req_q & addr_ok_i;
  assign resp_o = wait_q & data_ok_i;

  // req stays up until accepted; wait covers the data phase afterwards.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_q  <= 1'b0;
      wait_q <= 1'b0;
    end else begin
      req_q  <= issue_i | (req_q & ~addr_ok_i);
      wait_q <= acc_o | (wait_q & ~data_ok_i);
    end
  end

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multicycle instruction sequencer: fetch / decode / execute / memory /
// writeback FSM, PC update, retired-instruction counter and debug PC.
module mc_seq_ctrl
  import mc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                CNT_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(MC_RESET_PC)
) (
  input  logic              clk,
  input  logic              resetn,
  // instruction fetch
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [31:0]       inst_rdata,
  // decoder classification (valid in ID)
  input  logic              dec_is_load,
  input  logic              dec_is_store,
  input  logic              dec_is_br_only,
  input  logic              dec_wr_en,
  // branch resolution
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  // data memory
  output logic              data_req,
  output logic              data_wr,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  // status
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic              st_id,
  output logic              st_exe,
  output logic              st_mem,
  output logic              st_wb,
  output logic              rf_we,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [ADDR_W-1:0] debug_wb_pc
);

  mc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, npc_q, next_pc, dbg_q;
  logic [31:0]       ir_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              dwr_q, rfwe_q;
  logic              i_acc, i_resp, d_acc, d_resp;
  logic              retire;
  mc_dec_t           dec;
  mc_cls_e           cls;

  assign dec = '{br_only: dec_is_br_only, load: dec_is_load,
                 store: dec_is_store, wr_en: dec_wr_en};
  assign cls = classify(dec);

  // Branch targets are forced word-aligned; sequential PC wraps naturally.
  assign next_pc = br_taken ? {br_target[ADDR_W-1:2], 2'b00}
                            : pc_q + ADDR_W'(4);

  // Low target bits are dropped by the alignment above.
  logic unused_br_lo;
  assign unused_br_lo = &{1'b0, br_target[1:0]};

  mc_req_port u_inst_port (
    .clk       (clk),
    .resetn    (resetn),
    .issue_i   (state_d == IF_REQ),
    .addr_ok_i (inst_addr_ok),
    .data_ok_i (inst_data_ok),
    .req_o     (inst_req),
    .acc_o     (i_acc),
    .resp_o    (i_resp)
  );

  mc_req_port u_data_port (
    .clk       (clk),
    .resetn    (resetn),
    .issue_i   (state_d == MEM_REQ),
    .addr_ok_i (data_addr_ok),
    .data_ok_i (data_data_ok),
    .req_o     (data_req),
    .acc_o     (d_acc),
    .resp_o    (d_resp)
  );

  // Next-state decode; handshake events come from the port trackers.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IF_REQ:   if (i_acc)  state_d = IF_WAIT;
      IF_WAIT:  if (i_resp) state_d = ID;
      ID:       state_d = (cls == CLS_BR) ? IF_REQ : EXE;
      EXE:      state_d = (cls == CLS_LOAD || cls == CLS_STORE) ? MEM_REQ : WB;
      MEM_REQ:  if (d_acc)  state_d = MEM_WAIT;
      MEM_WAIT: if (d_resp) state_d = (cls == CLS_LOAD) ? WB : IF_REQ;
      WB:       state_d = IF_REQ;
      default:  state_d = IF_REQ;
    endcase
  end

  // An instruction completes whenever control returns to fetch from a
  // terminal state; holding in IF_REQ or leaving reset does not count.
  assign retire = (state_d == IF_REQ) &&
                  (state_q == ID || state_q == MEM_WAIT || state_q == WB);

  // State, PC, IR, counters and registered control outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IF_REQ;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      dbg_q   <= '0;
      dwr_q   <= 1'b0;
      rfwe_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IF_WAIT && i_resp) ir_q <= inst_rdata;
      // Branch outcome is only sampled in ID; keep it for later retirement.
      if (state_q == ID) npc_q <= next_pc;
      if (retire) begin
        pc_q  <= (state_q == ID) ? next_pc : npc_q;
        cnt_q <= cnt_q + CNT_W'(1);
        dbg_q <= pc_q;
      end
      dwr_q  <= (state_d == MEM_REQ) && (cls == CLS_STORE);
      rfwe_q <= (state_d == WB) && dec_wr_en;
    end
  end

  assign inst_addr   = pc_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign data_wr     = dwr_q;
  assign rf_we       = rfwe_q;
  assign retire_cnt  = cnt_q;
  assign debug_wb_pc = dbg_q;

  assign st_id  = (state_q == ID);
  assign st_exe = (state_q == EXE);
  assign st_mem = (state_q == MEM_REQ) || (state_q == MEM_WAIT);
  assign st_wb  = (state_q == WB);

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Directed bench for mc_seq_ctrl: reset, zero-wait ALU, fetch stall,
// branch, load/store with delayed data, PC/counter wrap and mid-flight reset.
module tb_mc_seq_ctrl;

  localparam logic [31:0] RPC = 32'h1c00_0000;
  localparam int O_IFR = 0, O_IFW = 1, O_ID = 2, O_EXE = 3,
                 O_MRQ = 4, O_MWT = 5, O_WB = 6;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata;
  logic        dec_is_load, dec_is_store, dec_is_br_only, dec_wr_en;
  logic        br_taken;
  logic [31:0] br_target;

  logic        inst_req, data_req, data_wr, rf_we;
  logic [31:0] inst_addr, ir, pc, retire_cnt, debug_wb_pc;
  logic        st_id, st_exe, st_mem, st_wb;

  logic        w_inst_req, w_data_req, w_data_wr, w_rf_we;
  logic [31:0] w_inst_addr, w_ir, w_pc, w_debug_wb_pc;
  logic [3:0]  w_retire_cnt;
  logic        w_st_id, w_st_exe, w_st_mem, w_st_wb;

  int n_chk = 0, n_pass = 0;

  // memory responder knobs
  int   ia_wait = 0, id_wait = 0, da_wait = 0, dd_wait = 0;
  int   ia_cnt, id_cnt, da_cnt, dd_cnt;
  logic i_pend, d_pend;
  logic i_force = 1'b0, d_force = 1'b0;

  always #5 clk = ~clk;

  mc_seq_ctrl dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_is_br_only(dec_is_br_only), .dec_wr_en(dec_wr_en),
    .br_taken(br_taken), .br_target(br_target),
    .data_req(data_req), .data_wr(data_wr), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .ir(ir), .pc(pc), .st_id(st_id), .st_exe(st_exe), .st_mem(st_mem),
    .st_wb(st_wb), .rf_we(rf_we), .retire_cnt(retire_cnt),
    .debug_wb_pc(debug_wb_pc)
  );

  // Narrow-counter, top-of-space instance running in lockstep with dut.
  mc_seq_ctrl #(.ADDR_W(32), .CNT_W(4), .RESET_PC(32'hffff_fffc)) dut_w (
    .clk(clk), .resetn(resetn),
    .inst_req(w_inst_req), .inst_addr(w_inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_is_br_only(dec_is_br_only), .dec_wr_en(dec_wr_en),
    .br_taken(br_taken), .br_target(br_target),
    .data_req(w_data_req), .data_wr(w_data_wr), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .ir(w_ir), .pc(w_pc), .st_id(w_st_id), .st_exe(w_st_exe), .st_mem(w_st_mem),
    .st_wb(w_st_wb), .rf_we(w_rf_we), .retire_cnt(w_retire_cnt),
    .debug_wb_pc(w_debug_wb_pc)
  );

  assign inst_addr_ok = inst_req && (ia_cnt >= ia_wait);
  assign inst_data_ok = (i_pend && (id_cnt >= id_wait)) || i_force;
  assign data_addr_ok = data_req && (da_cnt >= da_wait);
  assign data_data_ok = (d_pend && (dd_cnt >= dd_wait)) || d_force;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ia_cnt <= 0; id_cnt <= 0; i_pend <= 1'b0;
    end else begin
      ia_cnt <= (!inst_req || inst_addr_ok) ? 0 : ia_cnt + 1;
      if (inst_req && inst_addr_ok) begin
        i_pend <= 1'b1; id_cnt <= 0;
      end else if (i_pend) begin
        if (inst_data_ok) i_pend <= 1'b0;
        id_cnt <= id_cnt + 1;
      end
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      da_cnt <= 0; dd_cnt <= 0; d_pend <= 1'b0;
    end else begin
      da_cnt <= (!data_req || data_addr_ok) ? 0 : da_cnt + 1;
      if (data_req && data_addr_ok) begin
        d_pend <= 1'b1; dd_cnt <= 0;
      end else if (d_pend) begin
        if (data_data_ok) d_pend <= 1'b0;
        dd_cnt <= dd_cnt + 1;
      end
    end
  end

  // Observed state from the status outputs (IF_REQ vs IF_WAIT via inst_req).
  function automatic int obs();
    if (st_id)  return O_ID;
    if (st_exe) return O_EXE;
    if (st_wb)  return O_WB;
    if (st_mem) return data_req ? O_MRQ : O_MWT;
    return inst_req ? O_IFR : O_IFW;
  endfunction

  task automatic set_dec(input logic br, input logic ld, input logic stq, input logic we);
    dec_is_br_only = br; dec_is_load = ld; dec_is_store = stq; dec_wr_en = we;
  endtask

  // Reset pulse; returns at the first negedge with inst_req up.
  task automatic do_reset();
    @(negedge clk) resetn = 1'b0;
    @(negedge clk);
    @(negedge clk) resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk) resetn = 1'b0;
    #1;
    n_chk++; if ({st_id, st_exe, st_mem, st_wb} !== 4'b0) $display("FAIL rst_st: got %b want 0000", {st_id, st_exe, st_mem, st_wb}); else n_pass++;
    n_chk++; if ({inst_req, data_req, data_wr, rf_we} !== 4'b0) $display("FAIL rst_ctl: got %b want 0000", {inst_req, data_req, data_wr, rf_we}); else n_pass++;
    n_chk++; if (pc !== RPC) $display("FAIL rst_pc: got %h want %h", pc, RPC); else n_pass++;
    n_chk++; if ({ir, retire_cnt, debug_wb_pc} !== 96'h0) $display("FAIL rst_regs: got %h %h %h want 0", ir, retire_cnt, debug_wb_pc); else n_pass++;
    @(negedge clk);
    n_chk++; if (inst_req !== 1'b0) $display("FAIL rst_hold_req: got %b want 0", inst_req); else n_pass++;
    resetn = 1'b1;
    #1;
    n_chk++; if (inst_req !== 1'b0) $display("FAIL rel_req0: got %b want 0", inst_req); else n_pass++;
    @(negedge clk);
    n_chk++; if (inst_req !== 1'b1 || inst_addr !== RPC) $display("FAIL rel_req1: got %b/%h want 1/%h", inst_req, inst_addr, RPC); else n_pass++;
  endtask

  task automatic test_alu();
    int exp_s[5];
    int pulses = 0;
    exp_s = '{O_IFW, O_ID, O_EXE, O_WB, O_IFR};
    ia_wait = 0; id_wait = 0;
    set_dec(1'b0, 1'b0, 1'b0, 1'b1);
    br_taken = 1'b0;
    inst_rdata = 32'h0012_3413;
    n_chk++; if (obs() !== O_IFR) $display("FAIL alu_start: got %0d want %0d", obs(), O_IFR); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rf_we) pulses++;
      n_chk++; if (obs() !== exp_s[i]) $display("FAIL alu_state%0d: got %0d want %0d", i, obs(), exp_s[i]); else n_pass++;
      n_chk++; if ($countones({st_id, st_exe, st_mem, st_wb}) > 1 || (inst_req && data_req)) $display("FAIL alu_excl%0d: got st=%b req=%b%b want exclusive", i, {st_id, st_exe, st_mem, st_wb}, inst_req, data_req); else n_pass++;
      if (i == 1) begin
        n_chk++; if (ir !== 32'h0012_3413) $display("FAIL alu_ir: got %h want 00123413", ir); else n_pass++;
      end
    end
    n_chk++; if (pc !== RPC + 32'd4) $display("FAIL alu_pc: got %h want %h", pc, RPC + 32'd4); else n_pass++;
    n_chk++; if (retire_cnt !== 32'd1) $display("FAIL alu_cnt: got %0d want 1", retire_cnt); else n_pass++;
    n_chk++; if (debug_wb_pc !== RPC) $display("FAIL alu_dbg: got %h want %h", debug_wb_pc, RPC); else n_pass++;
    n_chk++; if (pulses !== 1) $display("FAIL alu_rfwe: got %0d pulses want 1", pulses); else n_pass++;
  endtask

  // Fetch stall with a stray data_ok, then a taken branch-only instruction
  // whose load/wr flags must be overridden.
  task automatic test_stall_branch();
    int rfw = 0;
    ia_wait = 3;
    i_force = 1'b1;
    set_dec(1'b1, 1'b1, 1'b0, 1'b1);
    br_taken = 1'b1;
    br_target = 32'h1c00_0103;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (inst_req !== 1'b1 || inst_addr !== RPC + 32'd4) $display("FAIL stall_req%0d: got %b/%h want 1/%h", i, inst_req, inst_addr, RPC + 32'd4); else n_pass++;
      n_chk++; if (obs() !== O_IFR) $display("FAIL stall_state%0d: got %0d want %0d", i, obs(), O_IFR); else n_pass++;
      @(negedge clk);
    end
    i_force = 1'b0;
    ia_wait = 0;
    n_chk++; if (obs() !== O_IFW) $display("FAIL br_ifw: got %0d want %0d", obs(), O_IFW); else n_pass++;
    @(negedge clk);
    n_chk++; if (obs() !== O_ID) $display("FAIL br_id: got %0d want %0d", obs(), O_ID); else n_pass++;
    @(negedge clk);
    if (rf_we) rfw++;
    n_chk++; if (obs() !== O_IFR) $display("FAIL br_ret: got %0d want %0d", obs(), O_IFR); else n_pass++;
    n_chk++; if (pc !== 32'h1c00_0100) $display("FAIL br_pc: got %h want 1c000100", pc); else n_pass++;
    n_chk++; if (retire_cnt !== 32'd2 || debug_wb_pc !== RPC + 32'd4) $display("FAIL br_cnt: got %0d/%h want 2/%h", retire_cnt, debug_wb_pc, RPC + 32'd4); else n_pass++;
    n_chk++; if (rfw !== 0) $display("FAIL br_rfwe: got %0d want 0", rfw); else n_pass++;
    br_taken = 1'b0;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_load_store();
    int exp_l[9];
    int exp_st[8];
    int pulses;
    do_reset();
    da_wait = 0; dd_wait = 2;
    exp_l  = '{O_IFW, O_ID, O_EXE, O_MRQ, O_MWT, O_MWT, O_MWT, O_WB, O_IFR};
    exp_st = '{O_IFW, O_ID, O_EXE, O_MRQ, O_MWT, O_MWT, O_MWT, O_IFR};
    set_dec(1'b0, 1'b1, 1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (rf_we) pulses++;
      n_chk++; if (obs() !== exp_l[i]) $display("FAIL ld_state%0d: got %0d want %0d", i, obs(), exp_l[i]); else n_pass++;
      if (i == 3) begin
        n_chk++; if (data_req !== 1'b1 || data_wr !== 1'b0 || inst_req !== 1'b0) $display("FAIL ld_mreq: got req=%b wr=%b ireq=%b want 1 0 0", data_req, data_wr, inst_req); else n_pass++;
      end
      if (i == 7) begin
        n_chk++; if (rf_we !== 1'b1) $display("FAIL ld_wb_rfwe: got %b want 1", rf_we); else n_pass++;
      end
    end
    n_chk++; if (pulses !== 1) $display("FAIL ld_pulses: got %0d want 1", pulses); else n_pass++;
    set_dec(1'b0, 1'b0, 1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rf_we) pulses++;
      n_chk++; if (obs() !== exp_st[i]) $display("FAIL st_state%0d: got %0d want %0d", i, obs(), exp_st[i]); else n_pass++;
      if (i == 3) begin
        n_chk++; if (data_req !== 1'b1 || data_wr !== 1'b1) $display("FAIL st_mreq: got req=%b wr=%b want 1 1", data_req, data_wr); else n_pass++;
      end
    end
    n_chk++; if (pulses !== 0) $display("FAIL st_pulses: got %0d want 0", pulses); else n_pass++;
    n_chk++; if (retire_cnt !== 32'd2) $display("FAIL ls_cnt: got %0d want 2", retire_cnt); else n_pass++;
    n_chk++; if (pc !== RPC + 32'd8 || debug_wb_pc !== RPC + 32'd4) $display("FAIL ls_pc: got %h/%h want %h/%h", pc, debug_wb_pc, RPC + 32'd8, RPC + 32'd4); else n_pass++;
    dd_wait = 0;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    int cyc;
    do_reset();
    set_dec(1'b0, 1'b0, 1'b0, 1'b1);
    br_taken = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (obs() != O_IFR && cyc < 12);
      n_chk++; if (obs() !== O_IFR) $display("FAIL wrap_timeout%0d: got state %0d want %0d", k, obs(), O_IFR); else n_pass++;
      if (k == 0) begin
        n_chk++; if (w_pc !== 32'h0 || w_debug_wb_pc !== 32'hffff_fffc) $display("FAIL wrap_pc: got %h/%h want 0/fffffffc", w_pc, w_debug_wb_pc); else n_pass++;
      end
      if (k == 14) begin
        n_chk++; if (w_retire_cnt !== 4'd15) $display("FAIL wrap_cnt15: got %0d want 15", w_retire_cnt); else n_pass++;
      end
    end
    n_chk++; if (w_retire_cnt !== 4'd0) $display("FAIL wrap_cnt0: got %0d want 0", w_retire_cnt); else n_pass++;
    n_chk++; if (retire_cnt !== 32'd16 || pc !== RPC + 32'd64) $display("FAIL wrap_main: got %0d/%h want 16/%h", retire_cnt, pc, RPC + 32'd64); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    set_dec(1'b0, 1'b1, 1'b0, 1'b1);
    dd_wait = 20;
    while (obs() != O_MWT && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    n_chk++; if (obs() !== O_MWT) $display("FAIL mid_reach: got %0d want %0d", obs(), O_MWT); else n_pass++;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_chk++; if ({st_id, st_exe, st_mem, st_wb, data_req, inst_req} !== 6'b0 || pc !== RPC) $display("FAIL mid_rst: got st=%b dreq=%b ireq=%b pc=%h want 0 0 0 %h", {st_id, st_exe, st_mem, st_wb}, data_req, inst_req, pc, RPC); else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    ia_wait = 20;
    d_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if (st_mem !== 1'b0 || data_req !== 1'b0 || rf_we !== 1'b0 || pc !== RPC) $display("FAIL mid_late%0d: got mem=%b dreq=%b rfwe=%b pc=%h want 0 0 0 %h", i, st_mem, data_req, rf_we, pc, RPC); else n_pass++;
    end
    n_chk++; if (obs() !== O_IFR || retire_cnt !== 32'd0) $display("FAIL mid_end: got state %0d cnt %0d want %0d 0", obs(), retire_cnt, O_IFR); else n_pass++;
    d_force = 1'b0;
    ia_wait = 0;
    dd_wait = 0;
  endtask

  initial begin
    resetn = 1'b1;
    inst_rdata = 32'h0;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0);
    br_taken = 1'b0;
    br_target = 32'h0;
    test_reset();
    test_alu();
    test_stall_branch();
    test_load_store();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
